rf_wb_arbiter: RTL

- Write-back scheduler for the MIPS register file's single write port.
- Arbitrates write requests from three producers: ALU pipeline, load unit and the multi-cycle mul/div unit.
- Stages the winner into a one-deep write register that drives the register file's Rd/WriteData/WriteEn.
- Keeps a per-register pending scoreboard so decode can stall on registers with outstanding multi-cycle writes.

---
 rtl/rf_wb_arbiter_pkg.sv | 16 +
 rtl/rf_scoreboard.sv | 62 ++++++
 rtl/rf_wb_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared definitions for the register-file write-back scheduler:
// default datapath widths, write-source encoding and starvation limit.
package rf_wb_arbiter_pkg;

    localparam int unsigned WORDLENGTH           = 32;
    localparam int unsigned REG_ADDRESS_LENGTH   = 5;
    localparam int unsigned REG_FILE_SIZE        = 32;
    localparam int unsigned STARVE_LIMIT_DEFAULT = 4;

    typedef enum logic [1:0] {
        SRC_LD  = 2'd0,
        SRC_ALU = 2'd1,
        SRC_MD  = 2'd2
    } wb_src_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard for multi-cycle (mul/div) destinations.
// Tracks one bit per architectural register, reports the population
// count and answers the two decode source-register hazard queries.
module rf_scoreboard #(
    parameter int unsigned AW   = 5,
    parameter int unsigned NREG = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   set_en,
    input  logic [AW-1:0]          set_rd,
    input  logic                   clr_en,
    input  logic [AW-1:0]          clr_rd,
    input  logic [AW-1:0]          q_rs,
    input  logic [AW-1:0]          q_rt,
    output logic                   hazard,
    output logic [$clog2(NREG):0]  pend_cnt
);

    localparam int unsigned CW = $clog2(NREG) + 1;

    logic [NREG-1:0] pending;
    logic [NREG-1:0] pend_next;
    logic [CW-1:0]   cnt_next;

    // Next pending vector: clear first so a same-cycle set wins; r0 never pends.
    always_comb begin
        pend_next = pending;
        if (clr_en) begin
            pend_next[clr_rd] = 1'b0;
        end
        if (set_en && (set_rd != '0)) begin
            pend_next[set_rd] = 1'b1;
        end
    end

    // Population count of the updated vector so pend_cnt tracks pending exactly.
    always_comb begin
        cnt_next = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            cnt_next = cnt_next + CW'(pend_next[i]);
        end
    end

    // Pending vector and its count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending  <= '0;
            pend_cnt <= '0;
        end else begin
            pending  <= pend_next;
            pend_cnt <= cnt_next;
        end
    end

    // Decode hazard lookup; register 0 never reports a hazard.
    always_comb begin
        hazard = ((q_rs != '0) && pending[q_rs]) ||
                 ((q_rt != '0) && pending[q_rt]);
    end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back scheduler for the register file's single write port.
// Arbitrates load / ALU / mul-div producers, stages the winner into a
// one-deep write register and maintains the mul/div pending scoreboard.
module rf_wb_arbiter
    import rf_wb_arbiter_pkg::*;
#(
    parameter int unsigned DW           = WORDLENGTH,
    parameter int unsigned AW           = REG_ADDRESS_LENGTH,
    parameter int unsigned NREG         = REG_FILE_SIZE,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ld_valid,
    input  logic [AW-1:0]          ld_rd,
    input  logic [DW-1:0]          ld_data,
    output logic                   ld_ready,
    input  logic                   alu_valid,
    input  logic [AW-1:0]          alu_rd,
    input  logic [DW-1:0]          alu_data,
    output logic                   alu_ready,
    input  logic                   md_valid,
    input  logic [AW-1:0]          md_rd,
    input  logic [DW-1:0]          md_data,
    output logic                   md_ready,
    input  logic                   iss_en,
    input  logic [AW-1:0]          iss_rd,
    input  logic [AW-1:0]          q_rs,
    input  logic [AW-1:0]          q_rt,
    output logic                   hazard,
    output logic                   rf_we,
    output logic [AW-1:0]          rf_rd,
    output logic [DW-1:0]          rf_wdata,
    output logic [$clog2(NREG):0]  pend_cnt
);

    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic [SW-1:0] starve_cnt;
    logic          promote;
    logic          xfer;
    wb_src_e       grant_src;
    logic [AW-1:0] win_rd;
    logic [DW-1:0] win_data;
    logic          stage_md;

    assign promote = (starve_cnt == STARVE_MAX);
    assign xfer    = ld_ready | alu_ready | md_ready;

    // One-hot grant: LD > ALU > MD normally, MD first once starved; all low in reset.
    always_comb begin
        ld_ready  = 1'b0;
        alu_ready = 1'b0;
        md_ready  = 1'b0;
        if (reset) begin
            if (promote && md_valid) begin
                md_ready = 1'b1;
            end else if (ld_valid) begin
                ld_ready = 1'b1;
            end else if (alu_valid) begin
                alu_ready = 1'b1;
            end else if (md_valid) begin
                md_ready = 1'b1;
            end
        end
    end

    // Select the winning producer's destination and data.
    always_comb begin
        grant_src = SRC_LD;
        win_rd    = ld_rd;
        win_data  = ld_data;
        if (alu_ready) begin
            grant_src = SRC_ALU;
            win_rd    = alu_rd;
            win_data  = alu_data;
        end else if (md_ready) begin
            grant_src = SRC_MD;
            win_rd    = md_rd;
            win_data  = md_data;
        end
    end

    // Count consecutive cycles mul/div waited; saturates at the promotion point.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt <= '0;
        end else if (!md_valid || md_ready) begin
            starve_cnt <= '0;
        end else if (starve_cnt != STARVE_MAX) begin
            starve_cnt <= starve_cnt + SW'(1);
        end
    end

    // Staging register: writes to r0 complete the handshake but never assert rf_we.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_we    <= 1'b0;
            rf_rd    <= '0;
            rf_wdata <= '0;
            stage_md <= 1'b0;
        end else if (xfer) begin
            rf_we    <= (win_rd != '0);
            rf_rd    <= win_rd;
            rf_wdata <= win_data;
            stage_md <= (grant_src == SRC_MD);
        end else begin
            rf_we    <= 1'b0;
            stage_md <= 1'b0;
        end
    end

    rf_scoreboard #(
        .AW   (AW),
        .NREG (NREG)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .set_en   (iss_en),
        .set_rd   (iss_rd),
        .clr_en   (rf_we && stage_md),
        .clr_rd   (rf_rd),
        .q_rs     (q_rs),
        .q_rt     (q_rt),
        .hazard   (hazard),
        .pend_cnt (pend_cnt)
    );

endmodule
